// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: FSM encoding and parameter defaults.
package fetch_queue_pkg;
    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fq_state_t;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned DEPTH_DEF    = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of instruction-memory, redirect and IF/ID-side signals around the prefetch queue.
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc_plus4;
    logic            out_ready;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc_plus4,
        input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc_plus4,
        output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {instr, pc+4} entries; clear empties it in one cycle.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_clear) r_mem[r_wptr] <= i_wdata;
    end
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, buffers returns, and flushes on redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fq_state_t     r_state;
    fq_state_t     w_state_n;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_ret_pc;
    logic [31:0]   w_redir_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] w_inflight_n;
    logic [CW-1:0] w_cnt_n;
    logic [CW-1:0] w_occ;
    logic          r_req;
    logic          w_req_n;
    logic          w_xfer;
    logic          w_ret;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [63:0]   w_head;

    assign w_redir_pc   = bus.redirect_pc & 32'hFFFF_FFFC;
    assign w_xfer       = r_req && bus.imem_ready;
    // Returns with nothing outstanding are protocol errors and never counted.
    assign w_ret        = bus.imem_rvalid && (r_inflight != '0);
    assign w_push       = w_ret && (r_state == FETCH) && !bus.redirect && !w_full;
    assign w_pop        = !w_empty && bus.out_ready && !bus.redirect;
    assign w_inflight_n = r_inflight + CW'(w_xfer) - CW'(w_ret);
    assign w_cnt_n      = bus.redirect ? '0 : (w_occ + CW'(w_push) - CW'(w_pop));

    always_comb begin
        w_state_n = r_state;
        if (bus.redirect)
            w_state_n = (w_inflight_n != '0) ? DRAIN : FETCH;
        else if (r_state == DRAIN && r_drop == '0)
            w_state_n = FETCH;
    end

    // imem_req is registered from next-cycle state so it stays low throughout reset.
    assign w_req_n = (w_state_n == FETCH) &&
                     (({1'b0, w_cnt_n} + {1'b0, w_inflight_n}) < (CW+1)'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= FETCH;
            r_fetch_pc <= RESET_PC;
            r_ret_pc   <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
            r_req      <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_req      <= w_req_n;
            r_inflight <= w_inflight_n;
            if (bus.redirect) begin
                r_fetch_pc <= w_redir_pc;
                r_ret_pc   <= w_redir_pc;
                r_drop     <= w_inflight_n;
            end else begin
                if (w_xfer) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push) r_ret_pc <= r_ret_pc + 32'd4;
                if (r_state == DRAIN && w_ret) r_drop <= r_drop - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (bus.redirect),
        .i_wdata ({bus.imem_rdata, r_ret_pc + 32'd4}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_occ)
    );

    assign bus.imem_req     = r_req;
    assign bus.imem_addr    = r_fetch_pc;
    assign bus.out_valid    = !w_empty;
    assign bus.out_instr    = w_empty ? '0 : w_head[63:32];
    assign bus.out_pc_plus4 = w_empty ? '0 : w_head[31:0];
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a latency-programmable memory model and an expected-entry queue.
module tb_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    logic clk;
    logic rst;
    fetch_queue_if bus();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mreq_t       memq[$];
    logic [63:0] sb[$];
    logic [31:0] xlog[$];
    logic [31:0] plog[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          epoch   = 0;
    int          lat     = 1;
    int          pop_cnt = 0;
    int          k_rmode = 0;
    bit          k_ready = 1'b1;
    bit          k_oready = 1'b1;
    bit          k_ghost = 1'b0;
    bit          redir_done = 1'b0;
    logic [31:0] k_rpc = '0;
    logic [31:0] exp_pc = RESET_PC;
    logic        last_req = 1'b0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5C3_0F1E;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hBAD0_BAD0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit          do_redir;
        bit          ret_now;
        bit          stale;
        int          occ;
        mreq_t       r;
        logic [63:0] e;
        @(negedge clk);
        cyc++;
        ret_now  = (memq.size() != 0) && (memq[0].due <= cyc);
        do_redir = (k_rmode == 1) ||
                   (k_rmode == 2 && ret_now && bus.out_valid && bus.imem_req && k_ready && k_oready);
        redir_done = do_redir;
        if (do_redir) k_rmode = 0;
        occ      = sb.size();
        last_req = bus.imem_req;

        chk("out_valid", 32'(bus.out_valid), 32'(occ != 0));
        if (!bus.out_valid) begin
            chk("idle_instr", bus.out_instr, 32'h0);
            chk("idle_pc4", bus.out_pc_plus4, 32'h0);
        end
        if (bus.imem_req) begin
            stale = 1'b0;
            foreach (memq[i]) if (memq[i].epoch != epoch) stale = 1'b1;
            chk("req_in_drain", 32'(stale), 32'h0);
            chk("req_room", 32'(occ + memq.size() < DEPTH), 32'h1);
        end
        if (bus.out_valid && k_oready && !do_redir && sb.size() != 0) begin
            pop_cnt++;
            e = sb.pop_front();
            chk("pop_instr", bus.out_instr, e[63:32]);
            chk("pop_pc4", bus.out_pc_plus4, e[31:0]);
            plog.push_back(bus.out_pc_plus4);
        end

        bus.out_ready   = k_oready;
        bus.imem_ready  = k_ready;
        bus.redirect    = do_redir;
        bus.redirect_pc = k_rpc;
        if (bus.imem_req && k_ready && rst) begin
            chk("fetch_addr", bus.imem_addr, exp_pc);
            xlog.push_back(bus.imem_addr);
            r.addr  = bus.imem_addr;
            r.epoch = epoch;
            r.due   = cyc + lat;
            memq.push_back(r);
            exp_pc += 32'd4;
        end
        if (do_redir) begin
            epoch++;
            sb.delete();
            exp_pc = k_rpc & 32'hFFFF_FFFC;
        end
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        if (ret_now) begin
            r = memq.pop_front();
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = instr_of(r.addr);
            if (r.epoch == epoch) sb.push_back({instr_of(r.addr), r.addr + 32'd4});
        end else if (k_ghost && rst) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
            k_ghost = 1'b0;
        end
    endtask

    initial begin
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_req", 32'(bus.imem_req), 32'h0);
        chk("rst_addr", bus.imem_addr, RESET_PC);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        repeat (2) step();
        rst = 1'b1;

        // Streaming: 1-cycle memory, consumer always ready
        step();
        chk("first_req", 32'(last_req), 32'h1);
        repeat (2) step();
        chk("seq_n", 32'(xlog.size()), 32'd3);
        chk("seq_a0", qget(xlog, 0), 32'h0);
        chk("seq_a1", qget(xlog, 1), 32'h4);
        chk("seq_a2", qget(xlog, 2), 32'h8);
        repeat (4) step();
        chk("seq_p0", qget(plog, 0), 32'h4);
        chk("seq_p1", qget(plog, 1), 32'h8);
        chk("seq_p2", qget(plog, 2), 32'hC);

        // Consumer stall fills the queue
        k_oready = 1'b0;
        repeat (10) step();
        chk("stall_req", 32'(bus.imem_req), 32'h0);
        chk("stall_valid", 32'(bus.out_valid), 32'h1);
        k_ready = 1'b0; k_oready = 1'b1; pop_cnt = 0;
        repeat (8) step();
        chk("stall_held", 32'(pop_cnt), DEPTH);
        chk("stall_empty", 32'(bus.out_valid), 32'h0);

        // Redirect to 0x40 with two requests outstanding
        lat = 3; k_ready = 1'b1;
        repeat (2) step();
        k_ready = 1'b0; k_rmode = 1; k_rpc = 32'h40;
        step();
        xlog.delete(); plog.delete(); k_ready = 1'b1;
        for (int i = 0; i < 20 && plog.size() == 0; i++) step();
        chk("c_addr", qget(xlog, 0), 32'h40);
        chk("c_pc4", qget(plog, 0), 32'h44);

        // Redirect with return+pop, then second redirect while draining
        repeat (3) step();
        k_rmode = 2; k_rpc = 32'h200;
        for (int i = 0; i < 40 && !redir_done; i++) step();
        chk("d_trigger", 32'(redir_done), 32'h1);
        k_rmode = 1; k_rpc = 32'h80;
        step();
        xlog.delete(); plog.delete();
        for (int i = 0; i < 20 && plog.size() == 0; i++) step();
        chk("d_addr", qget(xlog, 0), 32'h80);
        chk("d_pc4", qget(plog, 0), 32'h84);
        repeat (10) step();

        // Memory back-pressure and address wrap
        k_ready = 1'b0;
        repeat (6) step();
        k_rmode = 1; k_rpc = 32'hFFFF_FFF8;
        step();
        for (int i = 0; i < 10 && !bus.imem_req; i++) step();
        repeat (3) begin
            step();
            chk("bp_req", 32'(bus.imem_req), 32'h1);
            chk("bp_addr", bus.imem_addr, 32'hFFFF_FFF8);
        end
        xlog.delete(); plog.delete(); k_ready = 1'b1;
        repeat (3) step();
        chk("wrap_a0", qget(xlog, 0), 32'hFFFF_FFF8);
        chk("wrap_a1", qget(xlog, 1), 32'hFFFF_FFFC);
        chk("wrap_a2", qget(xlog, 2), 32'h0);
        repeat (8) step();
        chk("wrap_p0", qget(plog, 0), 32'hFFFF_FFFC);
        chk("wrap_p1", qget(plog, 1), 32'h0);
        chk("wrap_p2", qget(plog, 2), 32'h4);

        // Reset mid-stream with 3 entries and 1 request outstanding
        k_ready = 1'b0;
        repeat (8) step();
        lat = 1; k_ready = 1'b1; k_oready = 1'b0;
        for (int i = 0; i < 20 && !(sb.size() == 3 && memq.size() == 1); i++) step();
        chk("f_setup", 32'(sb.size() == 3 && memq.size() == 1), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("f_valid", 32'(bus.out_valid), 32'h0);
        chk("f_instr", bus.out_instr, 32'h0);
        chk("f_pc4", bus.out_pc_plus4, 32'h0);
        chk("f_req", 32'(bus.imem_req), 32'h0);
        chk("f_addr", bus.imem_addr, RESET_PC);
        memq.delete(); sb.delete(); xlog.delete(); plog.delete();
        epoch++; exp_pc = RESET_PC; k_ghost = 1'b1; k_oready = 1'b1;
        repeat (2) step();
        chk("f_req_hold", 32'(bus.imem_req), 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 20 && plog.size() == 0; i++) step();
        chk("f_restart", qget(xlog, 0), RESET_PC);
        chk("f_pc4_first", qget(plog, 0), RESET_PC + 32'd4);
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
